// File: rtl/pattern_sequencer.sv
// Pattern sequencer: streams pattern-table entries to a pixel driver, requests a display, then holds.
// Optional freeze/replay of the current frame is compiled in with `define PATTERN_SEQ_FREEZE_EN.
module pattern_sequencer #(
  parameter logic [22:0] HOLD_CYCLES = 23'd5_000_000,
  parameter int unsigned NUM_ENTRIES = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] syncedSW,
  input  logic [7:0] color_array [NUM_ENTRIES],
  input  logic [2:0] pixel_array [NUM_ENTRIES],
  input  logic [6:0] max_num_loads,
  output logic       load_valid,
  output logic [2:0] load_pixel,
  output logic [7:0] load_color,
  input  logic       load_ready,
  output logic       disp_valid,
  input  logic       disp_ready,
  output logic [15:0] frame_count,
  output logic       busy
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDisp, StHold} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [22:0]     timer_q, timer_d;
  logic [15:0]     fc_q, fc_d;
  logic            pend_q, pend_d;
  logic [2:0]      mode_q, mode_d;
  logic            frame_start;
  logic            mode_change;
  logic [7:0]      cnt_inc;
  logic [6:0]      eff_loads;

`ifdef PATTERN_SEQ_FREEZE_EN
  logic [IdxW-1:0] start_q, start_d;
  logic            unused_sw;
  assign unused_sw = syncedSW[4];
`else
  logic            unused_sw;
  assign unused_sw = ^syncedSW[4:3];
`endif

  assign mode_change = (syncedSW[2:0] != mode_q);
  assign cnt_inc     = {1'b0, cnt_q} + 8'd1;
  assign eff_loads   = (max_num_loads == 7'd0) ? 7'd1 : max_num_loads;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    fc_d        = fc_q;
    mode_d      = syncedSW[2:0];
    pend_d      = pend_q | mode_change;
    frame_start = 1'b0;
`ifdef PATTERN_SEQ_FREEZE_EN
    start_d     = start_q;
`endif
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d     = StLoad;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
      end
      StLoad: begin
        if (load_ready) begin
          idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
          cnt_d = cnt_inc[6:0];
          // >= so a mid-frame shrink below the current count ends on the next transfer
          if (cnt_inc >= {1'b0, eff_loads}) state_d = StDisp;
        end
      end
      StDisp: begin
        if (disp_ready) begin
          fc_d    = fc_q + 16'd1;
          timer_d = HOLD_CYCLES - 23'd1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (timer_q == '0) begin
          cnt_d = '0;
`ifdef PATTERN_SEQ_FREEZE_EN
          if (syncedSW[3]) idx_d = start_q;
`endif
          if (enable) begin
            state_d     = StLoad;
            frame_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 23'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A pending mode change restarts the table and overrides a freeze restore
    if (frame_start) begin
      if (pend_q) idx_d = '0;
      pend_d = mode_change;
`ifdef PATTERN_SEQ_FREEZE_EN
      start_d = idx_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      fc_q    <= '0;
      pend_q  <= 1'b0;
      mode_q  <= syncedSW[2:0];
`ifdef PATTERN_SEQ_FREEZE_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      fc_q    <= fc_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
`ifdef PATTERN_SEQ_FREEZE_EN
      start_q <= start_d;
`endif
    end
  end

  assign load_valid  = (state_q == StLoad);
  assign disp_valid  = (state_q == StDisp);
  assign busy        = (state_q != StIdle);
  assign frame_count = fc_q;
  assign load_pixel  = load_valid ? pixel_array[idx_q] : '0;
  assign load_color  = load_valid ? color_array[idx_q] : '0;

endmodule
